// File: rtl/slt_unit_seq_if.sv
// Handshake/operand bundle for the serial compare unit.
//   start, abort, mode, a, b : requester -> unit
//   busy, done, C, lt, eq    : unit -> requester
// W must match the W of the slt_unit_seq instance it is attached to.
interface slt_unit_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic         abort;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] C;
    logic         lt;
    logic         eq;

    modport master (
        output start, abort, mode, a, b,
        input  busy, done, C, lt, eq
    );

    modport slave (
        input  start, abort, mode, a, b,
        output busy, done, C, lt, eq
    );
endinterface

// File: rtl/slt_unit_seq.sv
// Multi-cycle set-less-than unit. Compares a and b MSB first, DIGIT bits per
// clock, and returns a zero-extended 0/1 result plus raw lt/eq flags.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of slt_unit_seq_if (start/abort/mode/a/b in,
//            busy/done/C/lt/eq out)
// mode: 00 SLT signed, 01 SLTU, 10 SEQ, 11 SLE signed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// BUSY   | one digit compared and shifted out per clock
// DONE   | result just registered, done pulses; start here recaptures
module slt_unit_seq #(
    parameter int W          = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    slt_unit_seq_if.slave bus
);
    localparam int N  = W / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [W-1:0] MSB_MASK = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_q, dec_d;
    logic          lti_q, lti_d;
    logic          done_q, done_d;
    logic          res_q, res_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             diff, dec_n, lti_n, signed_mode;

    assign dig_a = sa_q[W-1 -: DIGIT];
    assign dig_b = sb_q[W-1 -: DIGIT];
    assign diff  = (dig_a != dig_b);
    assign dec_n = dec_q | diff;
    // Only the first differing digit decides the order.
    assign lti_n = dec_q ? lti_q : (dig_a < dig_b);
    // Flipping the sign bit maps two's complement onto offset binary, so the
    // unsigned digit compare yields the signed order.
    assign signed_mode = (bus.mode[1] == bus.mode[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            lti_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            lti_q   <= lti_d;
            done_q  <= done_d;
            res_q   <= res_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        lti_d   = lti_q;
        done_d  = 1'b0;
        res_d   = res_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (!bus.abort && bus.start) begin
                    mode_d  = bus.mode;
                    sa_d    = bus.a ^ (signed_mode ? MSB_MASK : '0);
                    sb_d    = bus.b ^ (signed_mode ? MSB_MASK : '0);
                    cnt_d   = CW'(N);
                    dec_d   = 1'b0;
                    lti_d   = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    dec_d = dec_n;
                    lti_d = lti_n;
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q - 1'b1;
                    if ((cnt_q == CW'(1)) ||
                        ((EARLY_EXIT != 0) && !dec_q && diff)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        lt_d    = lti_n;
                        eq_d    = ~dec_n;
                        case (mode_q)
                            2'b10:   res_d = ~dec_n;
                            2'b11:   res_d = lti_n | ~dec_n;
                            default: res_d = lti_n;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.done = done_q;
    assign bus.C    = {{(W-1){1'b0}}, res_q};
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;
endmodule

// File: tb/tb_slt_unit_seq.sv
module tb_slt_unit_seq;
    localparam int W = 32;
    localparam int N = 8;

    typedef struct {
        logic       c;
        logic       lt;
        logic       eq;
        int         lat;
        int         cap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];
    int   bcnt0, bcnt1;

    slt_unit_seq_if #(.W(W)) bus0 ();
    slt_unit_seq_if #(.W(W)) bus1 ();

    slt_unit_seq #(.W(W), .DIGIT(4), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    slt_unit_seq #(.W(W), .DIGIT(4), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse.
    task automatic mon(input int sel, input logic done, input logic busy,
                       input logic [31:0] c, input logic lt, input logic eq);
        exp_t e;
        int   bc;
        bc = (sel == 0) ? bcnt0 : bcnt1;
        if (done) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_done%0d", sel), 32'd1, 32'd0);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("C%0d", sel), c, {31'd0, e.c});
                chk($sformatf("lt%0d", sel), {31'd0, lt}, {31'd0, e.lt});
                chk($sformatf("eq%0d", sel), {31'd0, eq}, {31'd0, e.eq});
                chk($sformatf("latency%0d", sel), cyc - e.cap - 1, e.lat);
                chk($sformatf("busy_len%0d", sel), bc, e.lat);
            end
        end
        bc = busy ? bc + 1 : 0;
        if (sel == 0) bcnt0 = bc; else bcnt1 = bc;
    endtask

    always @(negedge clk) if (rst_n) mon(0, bus0.done, bus0.busy, bus0.C, bus0.lt, bus0.eq);
    always @(negedge clk) if (rst_n) mon(1, bus1.done, bus1.busy, bus1.C, bus1.lt, bus1.eq);

    // Called at a negedge; capture happens on the following posedge.
    task automatic issue(input int sel, input logic [1:0] m, input logic [31:0] av,
                         input logic [31:0] bv, input logic ec, input logic elt,
                         input logic eeq, input int lat, input bit push);
        exp_t e;
        e.c = ec; e.lt = elt; e.eq = eeq; e.lat = lat; e.cap = cyc;
        if (sel == 0) begin
            bus0.mode = m; bus0.a = av; bus0.b = bv; bus0.start = 1'b1;
            if (push) q0.push_back(e);
        end else begin
            bus1.mode = m; bus1.a = av; bus1.b = bv; bus1.start = 1'b1;
            if (push) q1.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs: the unit must work from its latched copies.
        if (sel == 0) begin
            bus0.start = 1'b0; bus0.mode = ~m; bus0.a = ~av; bus0.b = ~bv;
        end else begin
            bus1.start = 1'b0; bus1.mode = ~m; bus1.a = ~av; bus1.b = ~bv;
        end
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk($sformatf("done_timeout%0d", sel), 32'd1, 32'd0);
            if (sel == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap1;
        total = 0; bad = 0; bcnt0 = 0; bcnt1 = 0;
        rst_n = 1'b0;
        bus0.start = 0; bus0.abort = 0; bus0.mode = 0; bus0.a = 0; bus0.b = 0;
        bus1.start = 0; bus1.abort = 0; bus1.mode = 0; bus1.a = 0; bus1.b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
        chk("rst_done", {31'd0, bus0.done}, 32'd0);
        chk("rst_C", bus0.C, 32'd0);
        chk("rst_lt", {31'd0, bus0.lt}, 32'd0);
        chk("rst_eq", {31'd0, bus0.eq}, 32'd0);

        // Fixed-latency unit, directed vectors.
        issue(0, 2'b00, 32'd3, 32'd2, 0, 0, 0, N, 1);                 drain(0);
        issue(0, 2'b00, 32'd2, 32'd3, 1, 1, 0, N, 1);                 drain(0);
        issue(0, 2'b10, 32'h1234_5678, 32'h1234_5678, 1, 0, 1, N, 1); drain(0);
        issue(0, 2'b00, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, N, 1);         drain(0);
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, N, 1);         drain(0);
        issue(0, 2'b11, 32'h8000_0000, 32'h8000_0000, 1, 0, 1, N, 1); drain(0);
        issue(0, 2'b11, 32'd5, 32'hFFFF_FFFD, 0, 0, 0, N, 1);         drain(0);
        issue(0, 2'b10, 32'd1, 32'd2, 0, 1, 0, N, 1);                 drain(0);

        // Early-exit unit.
        issue(1, 2'b01, 32'h8000_0000, 32'd0, 0, 0, 0, 1, 1);         drain(1);
        issue(1, 2'b01, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1, N, 1); drain(1);
        issue(1, 2'b00, 32'h10, 32'h20, 1, 1, 0, 7, 1);               drain(1);
        issue(1, 2'b11, 32'hFFFF_FFFF, 32'd0, 1, 1, 0, 1, 1);         drain(1);

        // Back-to-back: start held high through DONE with a new pair.
        cap1 = cyc;
        issue(0, 2'b01, 32'h10, 32'h20, 1, 1, 0, N, 1);
        repeat (3) @(negedge clk);
        bus0.mode = 2'b00; bus0.a = 32'd7; bus0.b = 32'd7; bus0.start = 1'b1;
        q0.push_back('{c: 1'b0, lt: 1'b0, eq: 1'b1, lat: N, cap: cap1 + N + 1});
        while (cyc < cap1 + N + 1) @(negedge clk);
        chk("b2b_done_cycle", {31'd0, bus0.done}, 32'd1);
        @(negedge clk);
        bus0.start = 1'b0;
        chk("b2b_busy_again", {31'd0, bus0.busy}, 32'd1);
        drain(0);

        // Abort on the third BUSY cycle: no done, outputs hold.
        issue(0, 2'b10, 32'd0, 32'd0, 1, 0, 1, N, 0);
        repeat (2) @(negedge clk);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk("abort_busy", {31'd0, bus0.busy}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_C", bus0.C, 32'd0);
        chk("abort_eq", {31'd0, bus0.eq}, 32'd1);

        // Abort beats start in IDLE.
        bus0.start = 1'b1; bus0.abort = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.abort = 1'b0;
        chk("abort_prio_busy", {31'd0, bus0.busy}, 32'd0);

        // Asynchronous reset mid-compare.
        issue(0, 2'b00, 32'd2, 32'd3, 1, 1, 0, N, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus0.busy}, 32'd0);
        chk("arst_eq0", {31'd0, bus0.eq}, 32'd0);
        chk("arst_C1", bus1.C, 32'd0);
        chk("arst_lt1", {31'd0, bus1.lt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", {31'd0, bus0.busy}, 32'd0);
        issue(0, 2'b01, 32'd1, 32'd2, 1, 1, 0, N, 1);                 drain(0);

        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
